// File: rtl/bit_stream_packer.sv
// Packs a qualified serial bit stream into WIDTH-bit words and queues them in a DEPTH-entry FIFO.
// Optional per-word parity output is enabled with `define BIT_STREAM_PACKER_PARITY_EN.
module bit_stream_packer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         bit_in,
  input  logic                         bit_valid,
  input  logic                         flush,
  output logic [WIDTH-1:0]             word_out,
  output logic [$clog2(WIDTH+1)-1:0]   word_len,
  output logic                         word_valid,
  input  logic                         word_ready,
  output logic                         overflow,
  output logic [$clog2(DEPTH+1)-1:0]   level
`ifdef BIT_STREAM_PACKER_PARITY_EN
  ,
  output logic                         word_parity
`endif
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned IW = $clog2(WIDTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t            state, state_next;
  logic [WIDTH-1:0]  shreg, shreg_upd;
  logic [CW-1:0]     cnt, cnt_upd;
  logic [IW-1:0]     bit_pos;
  logic              push;

  // Bit positions are written directly so unfilled positions stay zero.
  always_comb begin
    if (MSB_FIRST != 0) bit_pos = IW'(WIDTH - 1) - IW'(cnt);
    else                bit_pos = IW'(cnt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      shreg <= push ? '0 : shreg_upd;
      cnt   <= push ? '0 : cnt_upd;
    end
  end

  // The sampled bit is applied before a same-cycle flush is evaluated.
  always_comb begin
    state_next = state;
    shreg_upd  = shreg;
    cnt_upd    = cnt;
    push       = 1'b0;
    if (bit_valid) begin
      shreg_upd[bit_pos] = bit_in;
      cnt_upd            = cnt + CW'(1);
    end
    case (state)
      IDLE: begin
        if (bit_valid) begin
          if (flush) begin
            push       = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = FILL;
          end
        end
      end
      FILL: begin
        if (cnt_upd == CW'(WIDTH)) begin
          push       = 1'b1;
          state_next = IDLE;
        end else if (flush) begin
          push       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  logic [WIDTH-1:0] mem_word [DEPTH];
  logic [CW-1:0]    mem_len  [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, rd_ptr_next, head_idx;
  logic [LW-1:0]    level_next;
  logic             pop, full, wr_en, ovf_next;
  logic [WIDTH-1:0] head_word;
  logic [CW-1:0]    head_len;

`ifdef BIT_STREAM_PACKER_PARITY_EN
  logic             mem_par [DEPTH];
  logic             push_par, head_par;
  assign push_par = ^shreg_upd;
`endif

  // FIFO control; word_out is a register tracking the post-edge head entry.
  always_comb begin
    pop         = word_valid && word_ready;
    full        = (level == LW'(DEPTH));
    wr_en       = push && (!full || pop);
    ovf_next    = push && full && !pop;
    level_next  = level + LW'(wr_en) - LW'(pop);
    rd_ptr_next = rd_ptr + PW'(pop);
    head_idx    = rd_ptr_next;
    head_word   = mem_word[head_idx];
    head_len    = mem_len[head_idx];
`ifdef BIT_STREAM_PACKER_PARITY_EN
    head_par    = mem_par[head_idx];
`endif
    if (wr_en && (wr_ptr == head_idx)) begin
      head_word = shreg_upd;
      head_len  = cnt_upd;
`ifdef BIT_STREAM_PACKER_PARITY_EN
      head_par  = push_par;
`endif
    end
    if (level_next == '0) begin
      head_word = '0;
      head_len  = '0;
`ifdef BIT_STREAM_PACKER_PARITY_EN
      head_par  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_word[wr_ptr] <= shreg_upd;
      mem_len[wr_ptr]  <= cnt_upd;
`ifdef BIT_STREAM_PACKER_PARITY_EN
      mem_par[wr_ptr]  <= push_par;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      word_valid <= 1'b0;
      word_out   <= '0;
      word_len   <= '0;
      overflow   <= 1'b0;
`ifdef BIT_STREAM_PACKER_PARITY_EN
      word_parity <= 1'b0;
`endif
    end else begin
      wr_ptr     <= wr_ptr + PW'(wr_en);
      rd_ptr     <= rd_ptr_next;
      level      <= level_next;
      word_valid <= (level_next != '0);
      word_out   <= head_word;
      word_len   <= head_len;
      overflow   <= ovf_next;
`ifdef BIT_STREAM_PACKER_PARITY_EN
      word_parity <= head_par;
`endif
    end
  end

endmodule

// File: tb/tb_bit_stream_packer.sv
// Directed bench for bit_stream_packer: an MSB-first and an LSB-first instance share all inputs.
module tb_bit_stream_packer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       flush = 1'b0;
  logic       word_ready = 1'b0;

  logic [7:0] m_word, l_word;
  logic [3:0] m_len, l_len;
  logic       m_valid, l_valid, m_ovf, l_ovf;
  logic [2:0] m_level, l_level;
`ifdef BIT_STREAM_PACKER_PARITY_EN
  logic       m_par, l_par;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bit_stream_packer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .flush(flush),
    .word_out(m_word), .word_len(m_len), .word_valid(m_valid), .word_ready(word_ready),
    .overflow(m_ovf), .level(m_level)
`ifdef BIT_STREAM_PACKER_PARITY_EN
    , .word_parity(m_par)
`endif
  );

  bit_stream_packer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .flush(flush),
    .word_out(l_word), .word_len(l_len), .word_valid(l_valid), .word_ready(word_ready),
    .overflow(l_ovf), .level(l_level)
`ifdef BIT_STREAM_PACKER_PARITY_EN
    , .word_parity(l_par)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends the top n bits of v, most significant first.
  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      bit_in    = v[7-i];
      bit_valid = 1'b1;
      step();
    end
    bit_valid = 1'b0;
  endtask

  initial begin
    // Reset
    step();
    step();
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_level", 32'(m_level), 32'd0);
    check("rst_word",  32'(m_word),  32'd0);
    check("rst_len",   32'(m_len),   32'd0);
    check("rst_ovf",   32'(m_ovf),   32'd0);
    rst = 1'b0;
    step();

    // Full word, ready high
    word_ready = 1'b1;
    send_bits(8'hB2, 8);
    check("full_valid",  32'(m_valid), 32'd1);
    check("full_word_m", 32'(m_word),  32'hB2);
    check("full_word_l", 32'(l_word),  32'h4D);
    check("full_len",    32'(m_len),   32'd8);
    check("full_level",  32'(m_level), 32'd1);
`ifdef BIT_STREAM_PACKER_PARITY_EN
    check("full_par_m", 32'(m_par), 32'd0);
    check("full_par_l", 32'(l_par), 32'd0);
`endif
    step();
    check("full_drain", 32'(m_level), 32'd0);

    // Partial word via flush alone
    send_bits(8'hC0, 3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("part_level",  32'(l_level), 32'd1);
    check("part_word_l", 32'(l_word),  32'h03);
    check("part_word_m", 32'(m_word),  32'hC0);
    check("part_len",    32'(l_len),   32'd3);
`ifdef BIT_STREAM_PACKER_PARITY_EN
    check("part_par", 32'(l_par), 32'd0);
`endif
    step();
    check("part_drain", 32'(l_level), 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("idle_flush_valid", 32'(l_valid), 32'd0);
    step();
    check("idle_flush_level", 32'(l_level), 32'd0);

    // Flush together with the completing bit
    word_ready = 1'b0;
    send_bits(8'hAA, 7);
    bit_in    = 1'b1;
    bit_valid = 1'b1;
    flush     = 1'b1;
    step();
    bit_valid = 1'b0;
    flush     = 1'b0;
    check("fb_level", 32'(m_level), 32'd1);
    check("fb_len",   32'(m_len),   32'd8);
    check("fb_word",  32'(m_word),  32'hAB);
    step();
    step();
    check("fb_single", 32'(m_level), 32'd1);
    word_ready = 1'b1;
    step();
    word_ready = 1'b0;
    check("fb_drain", 32'(m_level), 32'd0);

    // Overflow with consumer stalled
    send_bits(8'h11, 8);
    send_bits(8'h22, 8);
    send_bits(8'h33, 8);
    send_bits(8'h44, 8);
    check("ovf_level4", 32'(m_level), 32'd4);
    check("ovf_pre",    32'(m_ovf),   32'd0);
    send_bits(8'h55, 8);
    check("ovf_pulse", 32'(m_ovf),   32'd1);
    check("ovf_level", 32'(m_level), 32'd4);
    step();
    check("ovf_clear", 32'(m_ovf),  32'd0);
    check("ovf_head",  32'(m_word), 32'h11);
    word_ready = 1'b1;
    step();
    check("drain_2", 32'(m_word), 32'h22);
    step();
    check("drain_3", 32'(m_word), 32'h33);
    step();
    check("drain_4", 32'(m_word), 32'h44);
    step();
    check("drain_empty", 32'(m_level), 32'd0);
    word_ready = 1'b0;

    // Push and pop together while full
    send_bits(8'h01, 8);
    send_bits(8'h02, 8);
    send_bits(8'h03, 8);
    send_bits(8'h04, 8);
    send_bits(8'h05, 7);
    bit_in     = 1'b1;
    bit_valid  = 1'b1;
    word_ready = 1'b1;
    step();
    bit_valid = 1'b0;
    check("pp_ovf",   32'(m_ovf),   32'd0);
    check("pp_level", 32'(m_level), 32'd4);
    check("pp_head2", 32'(m_word),  32'h02);
    step();
    check("pp_head3", 32'(m_word), 32'h03);
    step();
    check("pp_head4", 32'(m_word), 32'h04);
    step();
    check("pp_head5", 32'(m_word),  32'h05);
    check("pp_last",  32'(m_level), 32'd1);
    step();
    check("pp_empty", 32'(m_level), 32'd0);
    word_ready = 1'b0;

    // Reset mid-word discards partial state
    send_bits(8'hF8, 5);
    rst = 1'b1;
    step();
    check("mrst_valid", 32'(m_valid), 32'd0);
    check("mrst_level", 32'(m_level), 32'd0);
    check("mrst_word",  32'(m_word),  32'd0);
    rst = 1'b0;
    step();
    send_bits(8'hE0, 3);
    check("mrst_nopush", 32'(l_level), 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("mrst_len",    32'(l_len),  32'd3);
    check("mrst_word_l", 32'(l_word), 32'h07);
    check("mrst_word_m", 32'(m_word), 32'hE0);
`ifdef BIT_STREAM_PACKER_PARITY_EN
    check("mrst_par", 32'(l_par), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
